// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0)
// and the loader/debug port (port 1). It uses round-robin req/gnt arbitration
// and allows one outstanding read with a fixed memory read latency.
//
//   state   | meaning
//   IDLE    | grants allowed; writes complete in the grant cycle
//   RD_WAIT | read outstanding; all requests held off until rvalid
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;      // port that wins when both request
  logic             id_q, id_d;        // port owning the outstanding read
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win;
  logic             win_we;

  // State, pointer, read owner and latency counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Arbitration, next state and all outputs; forced to zero while rst is high
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    win       = 1'b0;
    win_we    = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    busy      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // A lone requester wins outright; the pointer only breaks ties
          win    = (m0_req && m1_req) ? ptr_q : m1_req;
          win_we = win ? m1_we : m0_we;
          ptr_d  = ~win;
          m0_gnt = ~win;
          m1_gnt = win;
          mem_addr  = win ? m1_addr : m0_addr;
          mem_wdata = win ? m1_wdata : m0_wdata;
          mem_we    = win_we;
          mem_re    = ~win_we;
          if (!win_we) begin
            state_d = RD_WAIT;
            id_d    = win;
            cnt_d   = CNT_W'(RD_LAT);
          end
        end
      end
      RD_WAIT: begin
        busy = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          m0_rvalid = ~id_q;
          m1_rvalid = id_q;
          m0_rdata  = id_q ? '0 : mem_rdata;
          m1_rdata  = id_q ? mem_rdata : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_rdata  = '0;
      m1_rdata  = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: instance 0 uses RD_LAT=1 and instance 1
// uses RD_LAT=3. Stimulus pushes expected grant/rvalid events with their cycle
// numbers, and a negedge monitor pops and compares them as the DUTs produce them.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    int            inst;
    int            kind;   // 0 = grant, 1 = read data valid
    int            port;
    int            cyc;
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]    m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [1:0]    m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [1:0]    mem_we, mem_re, busy;
  logic [AW-1:0] m0_addr [2];
  logic [AW-1:0] m1_addr [2];
  logic [AW-1:0] mem_addr [2];
  logic [DW-1:0] m0_wdata [2];
  logic [DW-1:0] m1_wdata [2];
  logic [DW-1:0] m0_rdata [2];
  logic [DW-1:0] m1_rdata [2];
  logic [DW-1:0] mem_wdata [2];
  logic [DW-1:0] mem_rdata [2];

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 32'h8) ? 64'h1234 : {32'hD000_0000, a};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [DW-1:0] pipe [LAT];
    logic [DW-1:0] rdata_w;

    always @(posedge clk) begin
      pipe[0] <= mem_re[g] ? mem_fn(mem_addr[g]) : 64'hDEAD_BEEF_0000_0000;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rdata_w = pipe[LAT-1];
    assign mem_rdata[g] = rdata_w;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req[g]), .m0_we(m0_we[g]), .m0_addr(m0_addr[g]), .m0_wdata(m0_wdata[g]),
      .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]),
      .m1_req(m1_req[g]), .m1_we(m1_we[g]), .m1_addr(m1_addr[g]), .m1_wdata(m1_wdata[g]),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
      .mem_re(mem_re[g]), .mem_rdata(rdata_w), .busy(busy[g])
    );
  end

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic push_gnt(input int inst, input int port, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int c);
    exp_t e;
    e.inst = inst; e.kind = 0; e.port = port; e.cyc = c;
    e.we = we; e.re = ~we; e.addr = addr; e.data = wdata;
    sbq.push_back(e);
  endtask

  task automatic push_rv(input int inst, input int port, input logic [DW-1:0] data, input int c);
    exp_t e;
    e.inst = inst; e.kind = 1; e.port = port; e.cyc = c;
    e.we = 1'b0; e.re = 1'b0; e.addr = '0; e.data = data;
    sbq.push_back(e);
  endtask

  task automatic take(input exp_t g);
    exp_t e;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got inst%0d kind%0d port%0d cyc%0d, expected none",
               g.inst, g.kind, g.port, g.cyc);
      return;
    end
    e = sbq.pop_front();
    if (e.inst != g.inst || e.kind != g.kind || e.port != g.port || e.cyc != g.cyc ||
        e.we !== g.we || e.re !== g.re || e.addr !== g.addr || e.data !== g.data) begin
      n_fail++;
      $display("FAIL event: got inst%0d kind%0d port%0d cyc%0d we%b re%b addr %h data %h; expected inst%0d kind%0d port%0d cyc%0d we%b re%b addr %h data %h",
               g.inst, g.kind, g.port, g.cyc, g.we, g.re, g.addr, g.data,
               e.inst, e.kind, e.port, e.cyc, e.we, e.re, e.addr, e.data);
    end
  endtask

  // Monitor: pops expectations on each grant / rvalid and checks idle outputs
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t g;
      g.inst = k; g.cyc = cyc;
      if (m0_gnt[k] || m1_gnt[k]) begin
        g.kind = 0; g.we = mem_we[k]; g.re = mem_re[k]; g.addr = mem_addr[k]; g.data = mem_wdata[k];
        if (m0_gnt[k]) begin g.port = 0; take(g); end
        if (m1_gnt[k]) begin g.port = 1; take(g); end
      end else begin
        check("idle_mem", 64'(mem_addr[k]) | mem_wdata[k] | 64'({mem_we[k], mem_re[k]}), '0);
      end
      g.kind = 1; g.we = 1'b0; g.re = 1'b0; g.addr = '0;
      if (m0_rvalid[k]) begin g.port = 0; g.data = m0_rdata[k]; take(g); end
      else check("m0_rdata_idle", m0_rdata[k], '0);
      if (m1_rvalid[k]) begin g.port = 1; g.data = m1_rdata[k]; take(g); end
      else check("m1_rdata_idle", m1_rdata[k], '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int inst, input int port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      m0_req[inst] = req; m0_we[inst] = we; m0_addr[inst] = addr; m0_wdata[inst] = wdata;
    end else begin
      m1_req[inst] = req; m1_we[inst] = we; m1_addr[inst] = addr; m1_wdata[inst] = wdata;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int k = 0; k < 2; k++) begin
      drive(k, 0, 1'b0, 1'b0, '0, '0);
      drive(k, 1, 1'b0, 1'b0, '0, '0);
    end
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Contended writes from reset: m0, m1, m0, m1
    tick(); c = cyc;
    drive(0, 0, 1'b1, 1'b1, 32'h10, 64'hAA);
    drive(0, 1, 1'b1, 1'b1, 32'h20, 64'hBB);
    push_gnt(0, 0, 1'b1, 32'h10, 64'hAA, c);
    push_gnt(0, 1, 1'b1, 32'h20, 64'hBB, c + 1);
    push_gnt(0, 0, 1'b1, 32'h10, 64'hAA, c + 2);
    push_gnt(0, 1, 1'b1, 32'h20, 64'hBB, c + 3);
    repeat (4) tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // RD_LAT=1 read on port 0
    tick(); c = cyc;
    drive(0, 0, 1'b1, 1'b0, 32'h8, '0);
    push_gnt(0, 0, 1'b0, 32'h8, '0, c);
    push_rv(0, 0, 64'h1234, c + 1);
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    check("busy_lat1_wait", 64'(busy[0]), 64'd1);
    tick();
    check("busy_lat1_done", 64'(busy[0]), 64'd0);

    // Hold-off: m1 read, m0 write waits for first IDLE cycle
    tick(); c = cyc;
    drive(0, 1, 1'b1, 1'b0, 32'h30, '0);
    push_gnt(0, 1, 1'b0, 32'h30, '0, c);
    push_rv(0, 1, mem_fn(32'h30), c + 1);
    push_gnt(0, 0, 1'b1, 32'h40, 64'h55, c + 2);
    tick();
    drive(0, 1, 1'b0, 1'b0, '0, '0);
    drive(0, 0, 1'b1, 1'b1, 32'h40, 64'h55);
    tick();
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);

    // Async reset with m0 requesting; pointer was on port 1 before it
    tick();
    drive(0, 0, 1'b1, 1'b1, 32'h99, 64'h7);
    #1;
    check("gnt_before_rst", 64'(m0_gnt[0]), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_outputs", 64'({m0_gnt[0], m1_gnt[0], m0_rvalid[0], m1_rvalid[0],
                             mem_we[0], mem_re[0], busy[0]}) | 64'(mem_addr[0]) | mem_wdata[0], '0);
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b0;

    // Pointer back on port 0 after reset
    tick(); c = cyc;
    drive(0, 0, 1'b1, 1'b1, 32'h10, 64'hAA);
    drive(0, 1, 1'b1, 1'b1, 32'h20, 64'hBB);
    push_gnt(0, 0, 1'b1, 32'h10, 64'hAA, c);
    tick();
    drive(0, 0, 1'b0, 1'b0, '0, '0);
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // Lone requester m1: three back-to-back writes
    tick(); c = cyc;
    drive(0, 1, 1'b1, 1'b1, 32'h50, 64'h501);
    push_gnt(0, 1, 1'b1, 32'h50, 64'h501, c);
    push_gnt(0, 1, 1'b1, 32'h58, 64'h582, c + 1);
    push_gnt(0, 1, 1'b1, 32'h60, 64'h603, c + 2);
    tick();
    drive(0, 1, 1'b1, 1'b1, 32'h58, 64'h582);
    tick();
    drive(0, 1, 1'b1, 1'b1, 32'h60, 64'h603);
    tick();
    drive(0, 1, 1'b0, 1'b0, '0, '0);

    // RD_LAT=3 read on port 0
    tick(); c = cyc;
    drive(1, 0, 1'b1, 1'b0, 32'h8, '0);
    push_gnt(1, 0, 1'b0, 32'h8, '0, c);
    push_rv(1, 0, 64'h1234, c + 3);
    tick();
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    check("busy_lat3_c1", 64'(busy[1]), 64'd1);
    tick();
    check("busy_lat3_c2", 64'(busy[1]), 64'd1);
    tick();
    check("busy_lat3_c3", 64'(busy[1]), 64'd1);
    tick();
    check("busy_lat3_c4", 64'(busy[1]), 64'd0);

    // Withdrawal during RD_WAIT: m0 request dropped before any grant
    tick(); c = cyc;
    drive(1, 1, 1'b1, 1'b0, 32'h70, '0);
    push_gnt(1, 1, 1'b0, 32'h70, '0, c);
    push_rv(1, 1, mem_fn(32'h70), c + 3);
    tick();
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    drive(1, 0, 1'b1, 1'b1, 32'h78, 64'h66);
    tick();
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    repeat (2) tick();
    check("busy_after_withdraw", 64'(busy[1]), 64'd0);

    // Reset mid-read: the aborted read never returns
    tick(); c = cyc;
    drive(1, 1, 1'b1, 1'b0, 32'h88, '0);
    push_gnt(1, 1, 1'b0, 32'h88, '0, c);
    tick();
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    #1;
    check("busy_in_rst", 64'({busy[1], m1_rvalid[1]}), '0);
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("busy_after_abort", 64'(busy[1]), 64'd0);

    // Next m1 read completes normally
    tick(); c = cyc;
    drive(1, 1, 1'b1, 1'b0, 32'h90, '0);
    push_gnt(1, 1, 1'b0, 32'h90, '0, c);
    push_rv(1, 1, mem_fn(32'h90), c + 3);
    tick();
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    repeat (5) tick();

    check("sb_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
